cpu_ram_arbiter: RTL and testbench
==================================

// Module: cpu_ram_arbiter
// PURPOSE
//  Single-clock owner of CPU RAM port A. Replaces the combinational upload/CPU clock+data mux.
//  Shares the port between three requesters: the upload stream (buffered in a small FIFO),
//  the CPU, and an internal clear engine that zero-fills program space.
//  Drives cpu_hold into the CPU halt term. Sits between cpu, the uploader and cpu_memory.
// PARAMETERS
//  ADDR_W      12      RAM address width
//  DATA_W      8       RAM data width
//  FIFO_DEPTH  4       upload FIFO entries (power of 2, >=2)
//  CLEAR_BASE  12'h200 first address zeroed by the clear engine
// PORTS
//  clk           in   1       system clock (also clocks cpu_memory port A)
//  res_n         in   1       asynchronous reset, active low
//  upload_en     in   1       upload session active
//  upload_valid  in   1       upload byte presented
//  upload_ready  out  1       FIFO accepts byte this cycle
//  upload_addr   in   ADDR_W  upload byte address
//  upload_data   in   DATA_W  upload byte
//  cpu_req       in   1       CPU access request (level, held until cpu_gnt)
//  cpu_wr        in   1       1 = write, 0 = read
//  cpu_addr      in   ADDR_W  CPU address
//  cpu_wdata     in   DATA_W  CPU write data
//  cpu_gnt       out  1       CPU access issued to RAM this cycle
//  cpu_rvalid    out  1       cpu_rdata valid (1 cycle after read grant)
//  cpu_rdata     out  DATA_W  read data
//  cpu_hold      out  1       CPU must halt
//  clear_req     in   1       start zero-fill (pulse)
//  clear_busy    out  1       zero-fill in progress or pending
//  mem_en        out  1       RAM port enable
//  mem_write     out  1       RAM write strobe
//  mem_addr      out  ADDR_W  RAM address
//  mem_wdata     out  DATA_W  RAM write data
//  mem_rdata     in   DATA_W  RAM read data (registered in RAM, 1-cycle latency)
// BEHAVIOUR
//  Reset (res_n=0, async): state=RUN, FIFO empty, clear_pend=0. All outputs 0.
//  FSM states: RUN, UPLOAD, DRAIN, CLEAR.
//  - RUN: if clear_pend -> CLEAR; else if upload_en -> UPLOAD; else serve CPU.
//  - UPLOAD: stays while upload_en=1. On upload_en=0 -> DRAIN.
//  - DRAIN: FIFO empty -> RUN. If upload_en reasserts -> UPLOAD.
//  - CLEAR: counter runs CLEAR_BASE..all-ones, one zero write per cycle.
//    After the all-ones write -> RUN. Counter never wraps to 0.
//  Priority: clear > upload > CPU. RUN checks are combinational the same cycle.
//  - cpu_req with upload_en=1 in the same cycle: no grant.
//  cpu_gnt = state==RUN & cpu_req & !upload_en & !clear_pend (combinational).
//  - On grant, mem_* follow cpu_* the same cycle.
//  - Read: cpu_rvalid=1 and cpu_rdata=mem_rdata exactly 1 cycle later, registered.
//  - cpu_rdata holds its value otherwise. No rvalid for writes.
//  upload_ready = upload_en & !fifo_full & state!=CLEAR.
//  - A push happens when upload_valid & upload_ready.
//  - Push and pop may happen in the same cycle, including when full
//    (ready uses the pre-pop full flag).
//  FIFO pop (write to RAM) each cycle in UPLOAD/DRAIN while non-empty.
//  - Write ordering equals push ordering.
//  - Pointers are ADDR log2(FIFO_DEPTH)+1 bits and wrap modulo.
//  - Full when MSBs differ and LSBs are equal.
//  clear_req is latched into clear_pend in any state except CLEAR.
//  - clear_req during CLEAR is ignored.
//  - When pending during UPLOAD/DRAIN, the clear starts only after returning to RUN.
//  clear_busy = clear_pend | state==CLEAR.
//  cpu_hold = state!=RUN | upload_en | clear_pend. Registered, so it asserts one cycle after the cause.
//  - The CPU must not issue new requests while cpu_hold=1. The combinational cpu_gnt gating covers that first cycle.
//  mem_en=0 and mem_write=0 in cycles with no issued access. mem_wdata=0 during CLEAR.
//  Reset mid-operation: the FIFO is flushed and any partial clear is abandoned. No RAM access occurs in the reset cycle.
// TESTING
//  1. CPU read 0x300 in RUN -> cpu_gnt same cycle, mem_addr=0x300, cpu_rvalid next cycle with RAM byte.
//  2. Upload 8 bytes 0x200..0x207 back-to-back, upload_en drops after the last -> 8 writes in order,
//     DRAIN then RUN, cpu_hold low 1 cycle after the FIFO is empty.
//  3. Upload with FIFO_DEPTH=4 while push and pop happen every cycle -> upload_ready never drops;
//     a stalled pop (upload_en low->DRAIN) never loses or duplicates a byte.
//  4. clear_req in RUN -> 0xE00 zero writes 0x200..0xFFF, clear_busy high throughout, then RUN;
//     a second clear_req mid-clear is ignored.
//  5. clear_req during upload -> clear_busy=1 immediately, zero-fill begins only after the drain completes.
//  6. res_n pulsed low mid-upload with 3 bytes queued -> all outputs 0, FIFO empty,
//     no further RAM writes, state RUN.

Source files
------------

// File: rtl/cpu_ram_arbiter.sv
// Single-clock owner of CPU RAM port A: arbitrates the upload FIFO, the CPU and a
// zero-fill clear engine. Priority is clear > upload > CPU.
module cpu_ram_arbiter #(
   parameter int unsigned          ADDR_W     = 12,
   parameter int unsigned          DATA_W     = 8,
   parameter int unsigned          FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0]    CLEAR_BASE = 'h200
) (
   input  logic              clk,
   input  logic              res_n,
   input  logic              upload_en,
   input  logic              upload_valid,
   output logic              upload_ready,
   input  logic [ADDR_W-1:0] upload_addr,
   input  logic [DATA_W-1:0] upload_data,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   input  logic              clear_req,
   output logic              clear_busy,
   output logic              mem_en,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {RUN, UPLOAD, DRAIN, CLEAR} state_e;

   state_e            state_q, state_d;
   logic              clear_pend_q, clear_pend_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
   logic              hold_q, rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

   logic fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign push       = upload_valid & upload_ready;

   // Grant and ready are also masked by res_n so no access can be issued in the reset cycle.
   always_comb begin
      state_d      = state_q;
      clear_pend_d = clear_pend_q;
      clr_cnt_d    = clr_cnt_q;
      cpu_gnt      = 1'b0;
      pop          = 1'b0;
      mem_en       = 1'b0;
      mem_write    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      upload_ready = res_n & upload_en & ~fifo_full & (state_q != CLEAR);
      if (clear_req && state_q != CLEAR) begin
         clear_pend_d = 1'b1;
      end
      case (state_q)
         RUN: begin
            if (clear_pend_q) begin
               state_d      = CLEAR;
               clear_pend_d = 1'b0;
               clr_cnt_d    = CLEAR_BASE;
            end else if (upload_en) begin
               state_d = UPLOAD;
            end else if (cpu_req && res_n) begin
               cpu_gnt   = 1'b1;
               mem_en    = 1'b1;
               mem_write = cpu_wr;
               mem_addr  = cpu_addr;
               mem_wdata = cpu_wdata;
            end
         end
         UPLOAD, DRAIN: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               mem_en    = 1'b1;
               mem_write = 1'b1;
               mem_addr  = fifo_addr_q[rd_ptr_q[PTR_W-1:0]];
               mem_wdata = fifo_data_q[rd_ptr_q[PTR_W-1:0]];
            end
            if (state_q == UPLOAD) begin
               if (!upload_en) state_d = DRAIN;
            end else if (upload_en) begin
               state_d = UPLOAD;
            end else if (fifo_empty) begin
               state_d = RUN;
            end
         end
         CLEAR: begin
            mem_en    = 1'b1;
            mem_write = 1'b1;
            mem_addr  = clr_cnt_q;
            if (clr_cnt_q == '1) begin
               state_d = RUN;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q      <= RUN;
         clear_pend_q <= 1'b0;
         clr_cnt_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         hold_q       <= 1'b0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         clear_pend_q <= clear_pend_d;
         clr_cnt_q    <= clr_cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
         hold_q       <= (state_q != RUN) | upload_en | clear_pend_q;
         rvalid_q     <= cpu_gnt & ~cpu_wr;
         if (rvalid_q) rdata_q <= mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q[PTR_W-1:0]] <= upload_addr;
         fifo_data_q[wr_ptr_q[PTR_W-1:0]] <= upload_data;
      end
   end

   // RAM data arrives one cycle after the read grant; pass it through that cycle, then hold it.
   assign cpu_rdata  = rvalid_q ? mem_rdata : rdata_q;
   assign cpu_rvalid = rvalid_q;
   assign cpu_hold   = hold_q;
   assign clear_busy = clear_pend_q | (state_q == CLEAR);

endmodule

// File: tb/tb_cpu_ram_arbiter.sv
// Scoreboard bench for cpu_ram_arbiter: expected RAM writes are queued as stimulus is
// accepted and popped as the DUT issues them; a behavioural RAM supplies read data.
module tb_cpu_ram_arbiter;

   logic        clk = 1'b0;
   logic        res_n;
   logic        upload_en, upload_valid, upload_ready;
   logic [11:0] upload_addr;
   logic [7:0]  upload_data;
   logic        cpu_req, cpu_wr, cpu_gnt, cpu_rvalid, cpu_hold;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        clear_req, clear_busy;
   logic        mem_en, mem_write;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = '0;

   typedef struct packed {
      logic [11:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  ram [4096];
   logic [34:0] all_out;

   always #5 clk = ~clk;

   cpu_ram_arbiter #(
      .ADDR_W(12), .DATA_W(8), .FIFO_DEPTH(4), .CLEAR_BASE(12'h200)
   ) dut (
      .clk(clk), .res_n(res_n),
      .upload_en(upload_en), .upload_valid(upload_valid), .upload_ready(upload_ready),
      .upload_addr(upload_addr), .upload_data(upload_data),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
      .clear_req(clear_req), .clear_busy(clear_busy),
      .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   assign all_out = {upload_ready, cpu_gnt, cpu_rvalid, cpu_rdata, cpu_hold, clear_busy,
                     mem_en, mem_write, mem_addr, mem_wdata};

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_write) ram[mem_addr] <= mem_wdata;
         else           mem_rdata     <= ram[mem_addr];
      end
   end

   task automatic sample();
      wr_t e;
      @(negedge clk);
      if (mem_en === 1'b1 && mem_write === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d) begin
               errors++;
               $display("FAIL write_order: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, e.a, e.d);
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_writes(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         sample();
         advance();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d writes still pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic wait_hold_low(input string name, input int budget);
      int n = 0;
      sample();
      while (cpu_hold !== 1'b0 && n < budget) begin
         advance();
         sample();
         n++;
      end
      checks++;
      if (cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL %s: got cpu_hold=%b after %0d cycles, required 0", name, cpu_hold, budget);
      end
      advance();
   endtask

   task automatic push_clear_writes();
      wr_t e;
      for (int unsigned a = 'h200; a <= 'hFFF; a++) begin
         e.a = 12'(a);
         e.d = '0;
         exp_q.push_back(e);
      end
   endtask

   // Runs until every queued write is seen, counting cycles where clear_busy is low meanwhile.
   task automatic run_clear(input int reissue_at, output int busy_lows);
      int n = 0;
      busy_lows = 0;
      while (exp_q.size() != 0 && n < 4200) begin
         clear_req = (n == reissue_at);
         sample();
         if (exp_q.size() != 0 && clear_busy !== 1'b1) busy_lows++;
         advance();
         n++;
      end
      clear_req = 1'b0;
   endtask

   task automatic upload_stream(input logic [11:0] base, input logic [7:0] dbase, input int n,
                                input int gap_at, input int gap_len, output int lows);
      int  idx   = 0;
      int  guard = 0;
      int  gap   = gap_len;
      wr_t e;
      lows = 0;
      while (idx < n && guard < 200) begin
         if (idx == gap_at && gap > 0) begin
            upload_en    = 1'b0;
            upload_valid = 1'b0;
            repeat (gap) begin
               sample();
               advance();
            end
            gap = 0;
         end
         upload_en    = 1'b1;
         upload_valid = 1'b1;
         upload_addr  = base + 12'(idx);
         upload_data  = dbase + 8'(idx);
         sample();
         if (upload_ready === 1'b1) begin
            e.a = upload_addr;
            e.d = upload_data;
            exp_q.push_back(e);
            idx++;
         end else begin
            lows++;
         end
         advance();
         guard++;
      end
      upload_en    = 1'b0;
      upload_valid = 1'b0;
   endtask

   task automatic test_reset();
      res_n = 1'b0; cpu_req = 1'b1; upload_en = 1'b1; upload_valid = 1'b1; clear_req = 1'b0;
      sample();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, required 0", all_out);
      end
      cpu_req = 1'b0; upload_en = 1'b0; upload_valid = 1'b0;
      advance();
      res_n = 1'b1;
      advance();
      sample();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL idle_after_reset: got %h, required 0", all_out);
      end
      advance();
   endtask

   task automatic test_cpu_access();
      wr_t e;
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 12'h300; cpu_wdata = 8'hA5;
      e.a = 12'h300; e.d = 8'hA5;
      exp_q.push_back(e);
      sample();
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL cpu_write_gnt: got %b, required 1", cpu_gnt);
      end
      advance();
      cpu_req = 1'b0;
      sample();
      checks++;
      if (cpu_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL write_no_rvalid: got %b, required 0", cpu_rvalid);
      end
      advance();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h300;
      sample();
      checks++;
      if ({cpu_gnt, mem_en, mem_write, mem_addr} !== {3'b110, 12'h300}) begin
         errors++;
         $display("FAIL cpu_read_issue: got gnt/en/wr/addr=%b%b%b/%h, required 110/300",
                  cpu_gnt, mem_en, mem_write, mem_addr);
      end
      advance();
      cpu_req = 1'b0;
      sample();
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA5}) begin
         errors++;
         $display("FAIL cpu_read_data: got rvalid=%b rdata=%h, required 1/a5", cpu_rvalid, cpu_rdata);
      end
      advance();
      sample();
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'hA5}) begin
         errors++;
         $display("FAIL cpu_rdata_hold: got rvalid=%b rdata=%h, required 0/a5", cpu_rvalid, cpu_rdata);
      end
      advance();
      cpu_req = 1'b1; upload_en = 1'b1;
      sample();
      checks++;
      if (cpu_gnt !== 1'b0) begin
         errors++;
         $display("FAIL cpu_blocked_by_upload: got gnt=%b, required 0", cpu_gnt);
      end
      advance();
      cpu_req = 1'b0; upload_en = 1'b0;
      wait_hold_low("hold_after_blocked", 8);
   endtask

   task automatic test_upload();
      int lows;
      upload_stream(12'h200, 8'h10, 8, -1, 0, lows);
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL upload_ready_steady: got %0d not-ready cycles, required 0", lows);
      end
      wait_writes("upload_drain", 20);
      wait_hold_low("upload_hold_release", 6);
   endtask

   task automatic test_back_to_back();
      int lows;
      upload_stream(12'h240, 8'hC0, 8, 4, 3, lows);
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL b2b_ready_steady: got %0d not-ready cycles, required 0", lows);
      end
      wait_writes("b2b_drain", 20);
      wait_hold_low("b2b_hold_release", 6);
   endtask

   task automatic test_clear();
      int lows;
      clear_req = 1'b1;
      push_clear_writes();
      sample();
      advance();
      clear_req = 1'b0;
      run_clear(100, lows);
      wait_writes("clear_complete", 1);
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL clear_busy_held: got %0d low cycles, required 0", lows);
      end
      repeat (20) begin
         sample();
         advance();
      end
      sample();
      checks++;
      if ({clear_busy, cpu_hold} !== 2'b00) begin
         errors++;
         $display("FAIL clear_done_idle: got busy/hold=%b%b, required 00", clear_busy, cpu_hold);
      end
      advance();
   endtask

   task automatic test_clear_during_upload();
      int  idx = 0;
      int  lows;
      wr_t e;
      upload_en = 1'b1;
      for (int c = 0; c < 6; c++) begin
         upload_valid = 1'b1;
         upload_addr  = 12'h380 + 12'(idx);
         upload_data  = 8'h70 + 8'(idx);
         clear_req    = (c == 2);
         sample();
         if (c == 3) begin
            checks++;
            if (clear_busy !== 1'b1) begin
               errors++;
               $display("FAIL clear_pend_busy: got %b, required 1", clear_busy);
            end
         end
         if (upload_ready === 1'b1) begin
            e.a = upload_addr;
            e.d = upload_data;
            exp_q.push_back(e);
            idx++;
         end
         advance();
      end
      clear_req = 1'b0; upload_en = 1'b0; upload_valid = 1'b0;
      push_clear_writes();
      run_clear(-1, lows);
      wait_writes("upload_then_clear", 1);
      checks++;
      if (lows != 0) begin
         errors++;
         $display("FAIL clear_busy_pending: got %0d low cycles, required 0", lows);
      end
      wait_hold_low("clear_hold_release", 8);
   endtask

   task automatic test_reset_mid_upload();
      wr_t e;
      upload_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         upload_valid = 1'b1;
         upload_addr  = 12'h200 + 12'(k);
         upload_data  = 8'h60 + 8'(k);
         sample();
         if (upload_ready === 1'b1) begin
            e.a = upload_addr;
            e.d = upload_data;
            exp_q.push_back(e);
         end
         advance();
      end
      res_n = 1'b0; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 12'h201;
      exp_q.delete();
      sample();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL reset_mid_upload_outputs: got %h, required 0", all_out);
      end
      advance();
      upload_en = 1'b0; upload_valid = 1'b0; cpu_req = 1'b0;
      advance();
      res_n = 1'b1;
      repeat (10) begin
         sample();
         advance();
      end
      sample();
      checks++;
      if (all_out !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: got %h, required 0", all_out);
      end
      advance();
      cpu_req = 1'b1; cpu_addr = 12'h201;
      sample();
      checks++;
      if (cpu_gnt !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_run_gnt: got %b, required 1", cpu_gnt);
      end
      advance();
      cpu_req = 1'b0;
      sample();
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h61}) begin
         errors++;
         $display("FAIL pre_reset_write_kept: got rvalid=%b rdata=%h, required 1/61", cpu_rvalid, cpu_rdata);
      end
      advance();
   endtask

   initial begin
      res_n = 1'b0; upload_en = 1'b0; upload_valid = 1'b0; upload_addr = '0; upload_data = '0;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; clear_req = 1'b0;
      test_reset();
      test_cpu_access();
      test_upload();
      test_back_to_back();
      test_clear();
      test_clear_during_upload();
      test_reset_mid_upload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
